picosoc_native_wb_master: RTL and testbench

// - Converts the picorv32 native memory port (mem_valid/mem_ready) into Wishbone classic master cycles.
// - Sits between the CPU core and the Wishbone slaves, including the on-chip RAM slave.
// - One outstanding transfer; registered bus outputs; optional watchdog ends hung cycles.

---
 rtl/picosoc_wb_pkg.sv | 18 +
 rtl/picosoc_wb_watchdog.sv | 27 ++
 rtl/picosoc_native_wb_master.sv | 121 ++++++++++++
 tb/tb_picosoc_native_wb_master.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picosoc_wb_pkg.sv
// rtl/picosoc_wb_pkg.sv - shared states and constants for the native-to-Wishbone master
package picosoc_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL        = 4'hF;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

  // Reads fetch the whole word; writes select only the strobed bytes.
  function automatic logic [3:0] sel_for(input logic [3:0] wstrb);
    return (wstrb == 4'h0) ? WB_SEL_ALL : wstrb;
  endfunction

endpackage

// File: rtl/picosoc_wb_watchdog.sv
// rtl/picosoc_wb_watchdog.sv - bus-cycle watchdog, flags expiry on the LIMIT-th enabled cycle
module picosoc_wb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 16'd1;
    end
  end

  // count holds the number of completed enabled cycles, so expiry marks the LIMIT-th one
  assign expired = enable && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/picosoc_native_wb_master.sv
// rtl/picosoc_native_wb_master.sv - picorv32 native port to Wishbone classic master
// Optional watchdog enabled by defining PICOSOC_WB_TIMEOUT_EN.
module picosoc_native_wb_master
  import picosoc_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        bus_err_o
);

  state_t state, state_n;
  logic   accept, take_ack, take_err;
  logic   wd_expired;
  logic   unused_inputs;

  assign unused_inputs = ^{mem_instr, mem_addr[1:0], 16'(TIMEOUT_CYCLES)};

`ifdef PICOSOC_WB_TIMEOUT_EN
  picosoc_wb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (state != BUS),
    .enable  (state == BUS),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // err outranks ack, and a real slave response outranks the watchdog
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    take_ack = 1'b0;
    take_err = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_valid) begin
          accept  = 1'b1;
          state_n = BUS;
        end
      end
      BUS: begin
        if (wb_err_i) begin
          take_err = 1'b1;
          state_n  = DONE;
        end else if (wb_ack_i) begin
          take_ack = 1'b1;
          state_n  = DONE;
        end else if (wd_expired) begin
          take_err = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_err_o <= 1'b0;
    end else begin
      wb_cyc_o  <= (state_n == BUS);
      wb_stb_o  <= (state_n == BUS);
      mem_ready <= (state_n == DONE);
      if (accept) begin
        wb_adr_o <= {mem_addr[31:2], 2'b00};
        wb_dat_o <= mem_wdata;
        wb_sel_o <= sel_for(mem_wstrb);
        wb_we_o  <= |mem_wstrb;
      end else if (state_n != BUS) begin
        wb_we_o  <= 1'b0;
      end
      if (take_err) begin
        mem_rdata <= ERR_RDATA;
        bus_err_o <= 1'b1;
      end else if (take_ack && !wb_we_o) begin
        mem_rdata <= wb_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_native_wb_master.sv
// tb/tb_picosoc_native_wb_master.sv - randomized bench with a RAM slave and a word-level memory model
module tb_picosoc_native_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, bus_err_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] init_word [64];
  logic [31:0] ram       [64];
  logic [31:0] model     [64];
  int          slv_waits  = 0;
  int          slv_err_at = -1;
  bit          slv_silent = 1'b0;
  bit          slv_both   = 1'b0;
  int          bcnt;
  logic [31:0] last_rd;

  picosoc_native_wb_master #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_we_o   (wb_we_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .bus_err_o (bus_err_o)
  );

  always #5 clk = ~clk;

  // Registered, cyc-gated RAM slave: its ack stays high one extra cycle after the master drops stb.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      wb_dat_i <= '0;
      bcnt     <= 0;
      for (int i = 0; i < 64; i++) ram[i] <= init_word[i];
    end else begin
      wb_ack_i <= 1'b0;
      wb_err_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o) begin
        bcnt <= bcnt + 1;
        if (!slv_silent) begin
          if (slv_err_at >= 0 && bcnt == slv_err_at) begin
            wb_err_i <= 1'b1;
            if (slv_both) begin
              wb_ack_i <= 1'b1;
              wb_dat_i <= ram[wb_adr_o[7:2]];
            end
          end else if (slv_err_at < 0 && bcnt >= slv_waits) begin
            wb_ack_i <= 1'b1;
            wb_dat_i <= ram[wb_adr_o[7:2]];
            if (wb_we_o)
              for (int b = 0; b < 4; b++)
                if (wb_sel_o[b]) ram[wb_adr_o[7:2]][b*8 +: 8] <= wb_dat_o[b*8 +: 8];
          end
        end
      end else begin
        bcnt <= 0;
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // One CPU request; counts cycles from the request (n=1 is the first edge after it is presented).
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input bit keep, input int budget,
                      output logic [31:0] rd, output int t_cyc, output int t_rdy, output int cyc_hi,
                      output logic [31:0] b_adr, output logic [3:0] b_sel, output logic b_we,
                      output bit stable, output bit ok);
    logic [31:0] b_dat;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_instr = 1'($urandom_range(0, 1));
    rd = '0; t_cyc = -1; t_rdy = -1; cyc_hi = 0; ok = 1'b0; stable = 1'b1;
    b_adr = '0; b_sel = '0; b_we = 1'b0; b_dat = '0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (wb_stb_o !== wb_cyc_o) stable = 1'b0;
      if (wb_cyc_o) begin
        cyc_hi++;
        if (t_cyc < 0) begin
          t_cyc = n; b_adr = wb_adr_o; b_sel = wb_sel_o; b_we = wb_we_o; b_dat = wb_dat_o;
        end else if (wb_adr_o !== b_adr || wb_sel_o !== b_sel || wb_we_o !== b_we || wb_dat_o !== b_dat) begin
          stable = 1'b0;
        end
      end
      if (mem_ready) begin
        rd = mem_rdata; t_rdy = n; ok = 1'b1;
        break;
      end
    end
    if (!keep) begin
      mem_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, mem_ready, bus_err_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got cyc/stb/we/ready/err=%b want 00000", {wb_cyc_o, wb_stb_o, wb_we_o, mem_ready, bus_err_o});
    end
    vectors++;
    if ({mem_rdata, wb_adr_o, wb_dat_o, wb_sel_o} !== 100'b0) begin
      miscompares++;
      $display("FAIL reset_data: got rdata=%h adr=%h dat=%h sel=%h want all 0", mem_rdata, wb_adr_o, wb_dat_o, wb_sel_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [31:0] rd, ba; logic [3:0] bs; logic bw; int tc, tr, ch; bit st, ok;
    slv_waits = 0;
    xfer(32'h10, 32'h0, 4'h0, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (tc !== 1 || tr !== 3) begin
      miscompares++; $display("FAIL read_latency: got cyc@%0d ready@%0d want cyc@1 ready@3", tc, tr);
    end
    vectors++;
    if (rd !== 32'h12345678) begin
      miscompares++; $display("FAIL read_rdata: got %h want 12345678", rd);
    end
    vectors++;
    if (bs !== 4'hF || bw !== 1'b0 || ba !== 32'h10 || !st) begin
      miscompares++; $display("FAIL read_bus: got sel=%h we=%b adr=%h stable=%b want F 0 00000010 1", bs, bw, ba, st);
    end
    last_rd = rd;
  endtask

  task automatic test_write();
    logic [31:0] rd, ba; logic [3:0] bs; logic bw; int tc, tr, ch; bit st, ok;
    model[8] = merge(model[8], 32'hAABBCCDD, 4'b0101);
    xfer(32'h22, 32'hAABBCCDD, 4'b0101, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (ba !== 32'h20 || bs !== 4'b0101 || bw !== 1'b1 || tr !== 3) begin
      miscompares++; $display("FAIL write_bus: got adr=%h sel=%b we=%b ready@%0d want 00000020 0101 1 3", ba, bs, bw, tr);
    end
    vectors++;
    if (ram[8] !== model[8]) begin
      miscompares++; $display("FAIL write_bytes: got %h want %h", ram[8], model[8]);
    end
    vectors++;
    if (rd !== last_rd) begin
      miscompares++; $display("FAIL write_rdata_kept: got %h want %h", rd, last_rd);
    end
    vectors++;
    if (wb_we_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
      miscompares++; $display("FAIL write_we_idle: got we=%b cyc=%b want 0 0", wb_we_o, wb_cyc_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2, a1, a2, ba; logic [3:0] bs; logic bw; int tc1, tr1, tc2, tr2, ch; bit st, ok1, ok2;
    for (int k = 0; k < 3; k++) begin
      slv_waits = $urandom_range(0, 2);
      a1 = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      a2 = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      xfer(a1, 32'h0, 4'h0, 1'b1, 50, r1, tc1, tr1, ch, ba, bs, bw, st, ok1);
      xfer(a2, 32'h0, 4'h0, 1'b0, 50, r2, tc2, tr2, ch, ba, bs, bw, st, ok2);
      vectors++;
      if (r1 !== model[a1[7:2]] || r2 !== model[a2[7:2]]) begin
        miscompares++; $display("FAIL b2b_rdata: got %h %h want %h %h", r1, r2, model[a1[7:2]], model[a2[7:2]]);
      end
      vectors++;
      if (tr1 !== 3 + slv_waits || tc2 !== 2 || tr2 !== 4 + slv_waits) begin
        miscompares++;
        $display("FAIL b2b_timing: got ready1@%0d cyc2@%0d ready2@%0d want %0d 2 %0d", tr1, tc2, tr2, 3 + slv_waits, 4 + slv_waits);
      end
      last_rd = r2;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, ba, a, d, exp_adr; logic [3:0] bs, s, exp_sel; logic bw; int tc, tr, ch, exp_tc; bit st, ok, keep, prev_keep;
    prev_keep = 1'b0;
    for (int k = 0; k < 24; k++) begin
      a = 32'($urandom_range(0, 255)) | 32'h4000_0000;
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      keep = (k == 23) ? 1'b0 : 1'($urandom_range(0, 1));
      slv_waits = $urandom_range(0, 3);
      exp_tc  = prev_keep ? 2 : 1;
      exp_adr = a & 32'hFFFF_FFFC;
      exp_sel = (s == 4'h0) ? 4'hF : s;
      xfer(a, d, s, keep, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
      if (s != 4'h0) model[a[7:2]] = merge(model[a[7:2]], d, s);
      else if (ok) begin
        vectors++;
        if (rd !== model[a[7:2]]) begin
          miscompares++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rd, model[a[7:2]]);
        end
        last_rd = model[a[7:2]];
      end
      vectors++;
      if (!ok || tc !== exp_tc || tr !== exp_tc + 2 + slv_waits) begin
        miscompares++; $display("FAIL rand_timing[%0d]: got cyc@%0d ready@%0d want %0d %0d", k, tc, tr, exp_tc, exp_tc + 2 + slv_waits);
      end
      vectors++;
      if (ba !== exp_adr || bs !== exp_sel || bw !== (s != 4'h0) || !st) begin
        miscompares++;
        $display("FAIL rand_bus[%0d]: got adr=%h sel=%h we=%b stable=%b want %h %h %b 1", k, ba, bs, bw, st, exp_adr, exp_sel, s != 4'h0);
      end
      if (s != 4'h0) begin
        vectors++;
        if (rd !== last_rd) begin
          miscompares++; $display("FAIL rand_wr_rdata[%0d]: got %h want %h", k, rd, last_rd);
        end
      end
      prev_keep = keep;
    end
    vectors++;
    for (int i = 0; i < 64; i++) begin
      if (ram[i] !== model[i]) begin
        miscompares++; $display("FAIL rand_ram[%0d]: got %h want %h", i, ram[i], model[i]);
        break;
      end
    end
  endtask

  task automatic test_err();
    logic [31:0] rd, ba; logic [3:0] bs; logic bw; int tc, tr, ch; bit st, ok;
    slv_err_at = 1;
    xfer(32'h40, 32'h0, 4'h0, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (tr !== 4 || rd !== 32'hDEADBEEF || bus_err_o !== 1'b1) begin
      miscompares++; $display("FAIL err_read: got ready@%0d rdata=%h err=%b want 4 deadbeef 1", tr, rd, bus_err_o);
    end
    slv_err_at = 0; slv_both = 1'b1;
    xfer(32'h44, 32'h0, 4'h0, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (tr !== 3 || rd !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL err_over_ack: got ready@%0d rdata=%h want 3 deadbeef", tr, rd);
    end
    slv_err_at = -1; slv_both = 1'b0; slv_waits = 0;
    xfer(32'h48, 32'h0, 4'h0, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (rd !== model[18] || bus_err_o !== 1'b1) begin
      miscompares++; $display("FAIL err_sticky: got rdata=%h err=%b want %h 1", rd, bus_err_o, model[18]);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd, ba; logic [3:0] bs; logic bw; int tc, tr, ch; bit st, ok;
`ifdef PICOSOC_WB_TIMEOUT_EN
    slv_silent = 1'b1;
    xfer(32'h50, 32'h0, 4'h0, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (!ok || ch !== 8 || tr !== 9 || rd !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL timeout_abort: got ok=%b cyc_cycles=%0d ready@%0d rdata=%h want 1 8 9 deadbeef", ok, ch, tr, rd);
    end
    slv_silent = 1'b0; slv_waits = 6;
    xfer(32'h54, 32'h0, 4'h0, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (tr !== 9 || rd !== model[21]) begin
      miscompares++; $display("FAIL timeout_ack_wins: got ready@%0d rdata=%h want 9 %h", tr, rd, model[21]);
    end
    slv_waits = 0;
`else
    slv_silent = 1'b1;
    xfer(32'h50, 32'h0, 4'h0, 1'b0, 1000, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (ok || ch !== 1000) begin
      miscompares++; $display("FAIL no_timeout_hold: got ok=%b cyc_cycles=%0d want 0 1000", ok, ch);
    end
`endif
  endtask

  task automatic test_reset_mid_bus();
    logic [31:0] rd, ba; logic [3:0] bs; logic bw; int tc, tr, ch; bit st, ok;
    slv_silent = 1'b1;
    mem_valid = 1'b1; mem_addr = 32'h60; mem_wstrb = 4'h0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    vectors++;
    if (wb_cyc_o !== 1'b1) begin
      miscompares++; $display("FAIL midbus_cyc: got %b want 1", wb_cyc_o);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({wb_cyc_o, wb_stb_o, mem_ready, bus_err_o} !== 4'b0 || mem_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL midbus_reset: got cyc/stb/ready/err=%b rdata=%h want 0000 0", {wb_cyc_o, wb_stb_o, mem_ready, bus_err_o}, mem_rdata);
    end
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; slv_silent = 1'b0; slv_waits = 0;
    for (int i = 0; i < 64; i++) model[i] = init_word[i];
    @(negedge clk);
    xfer(32'h10, 32'h0, 4'h0, 1'b0, 50, rd, tc, tr, ch, ba, bs, bw, st, ok);
    vectors++;
    if (!ok || tr !== 3 || rd !== model[4] || bus_err_o !== 1'b0) begin
      miscompares++; $display("FAIL post_reset_read: got ok=%b ready@%0d rdata=%h err=%b want 1 3 %h 0", ok, tr, rd, bus_err_o, model[4]);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      init_word[i] = $urandom;
    end
    init_word[4] = 32'h12345678;
    for (int i = 0; i < 64; i++) model[i] = init_word[i];
    last_rd = '0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_random();
    test_err();
    test_timeout();
    test_reset_mid_bus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
